// File: rtl/proc_pkg.sv
// Shared processor package: default widths, writeback requester ids
// and small helpers used across pipeline blocks.
package proc_pkg;

  localparam int BUS_WIDTH_DEF = 32;
  localparam int REG_DPTH_DEF  = 32;
  localparam int AW_DEF        = $clog2(REG_DPTH_DEF);
  localparam int NREQ_DEF      = 3;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proc_wb_arbiter_if.sv
// Writeback request bus: NREQ sources, each with valid/ready,
// destination register and data, packed as flat slices.
interface proc_wb_arbiter_if
  import proc_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int AW        = AW_DEF,
  parameter int BUS_WIDTH = BUS_WIDTH_DEF
) ();

  logic [NREQ-1:0]           vld;
  logic [NREQ-1:0]           rdy;
  logic [NREQ*AW-1:0]        add;
  logic [NREQ*BUS_WIDTH-1:0] data;

  modport master (
    output vld,
    output add,
    output data,
    input  rdy
  );

  modport slave (
    input  vld,
    input  add,
    input  data,
    output rdy
  );

endinterface

// File: rtl/proc_rr_arb.sv
// Round-robin picker: search from ptr with wrap, first valid wins,
// next pointer is one past the winner.
module proc_rr_arb
  import proc_pkg::*;
#(
  parameter int N = 3,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  vld,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] nxt_ptr,
  output logic          any
);

  typedef logic [PW:0] sum_t;

  sum_t          sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt     = '0;
    nxt_ptr = ptr;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + sum_t'(k);
      if (sum >= sum_t'(N))
        sum = sum - sum_t'(N);
      idx = sum[PW-1:0];
      if (!any && vld[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        if (idx == PW'(N - 1))
          nxt_ptr = '0;
        else
          nxt_ptr = idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/proc_wb_arbiter.sv
// Writeback arbiter: round-robin access to the single register-file
// write port, plus the busy scoreboard that drives decode hazards.
module proc_wb_arbiter
  import proc_pkg::*;
#(
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int REG_DPTH  = REG_DPTH_DEF,
  parameter int NREQ      = NREQ_DEF,
  localparam int AW = $clog2(REG_DPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  proc_wb_arbiter_if.slave     wb,
  input  logic                 i_issue_vld,
  input  logic [AW-1:0]        i_issue_rd,
  input  logic [AW-1:0]        i_rega_add,
  input  logic [AW-1:0]        i_regb_add,
  output logic                 o_hazard_a,
  output logic                 o_hazard_b,
  output logic                 o_reg_we,
  output logic [AW-1:0]        o_regw_add,
  output logic [BUS_WIDTH-1:0] o_reg_data,
  output logic [REG_DPTH-1:0]  o_busy
);

  localparam int PW = ptr_w(NREQ);

  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        ptr_nxt;
  logic [NREQ-1:0]      gnt;
  logic                 any;
  logic [AW-1:0]        sel_add;
  logic [BUS_WIDTH-1:0] sel_data;
  logic [REG_DPTH-1:0]  busy_q;
  logic [REG_DPTH-1:0]  busy_nxt;

  proc_rr_arb #(
    .N (NREQ)
  ) u_arb (
    .vld     (wb.vld),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .nxt_ptr (ptr_nxt),
    .any     (any)
  );

  assign wb.rdy = rst ? '0 : gnt;

  always_comb begin
    sel_add  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_add  = wb.add[i*AW +: AW];
        sel_data = wb.data[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // x0 grants still handshake but never reach the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      o_reg_we   <= 1'b0;
      o_regw_add <= '0;
      o_reg_data <= '0;
    end else begin
      o_reg_we <= any && (sel_add != '0);
      if (any) begin
        ptr_q      <= ptr_nxt;
        o_regw_add <= sel_add;
        o_reg_data <= sel_data;
      end
    end
  end

  // set after clear: a fresh issue outranks a commit to the same reg
  always_comb begin
    busy_nxt = busy_q;
    if (o_reg_we && (o_regw_add != '0))
      busy_nxt[o_regw_add] = 1'b0;
    if (i_issue_vld && (i_issue_rd != '0))
      busy_nxt[i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_nxt;
  end

  assign o_busy     = busy_q;
  assign o_hazard_a = busy_q[i_rega_add];
  assign o_hazard_b = busy_q[i_regb_add];

endmodule

// File: tb/tb_proc_wb_arbiter.sv
// Directed bench for proc_wb_arbiter: vector table for arbitration
// and hazards, hand sequences for latency and scoreboard corners.
module tb_proc_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        i_issue_vld;
  logic [4:0]  i_issue_rd;
  logic [4:0]  i_rega_add;
  logic [4:0]  i_regb_add;
  logic        o_hazard_a;
  logic        o_hazard_b;
  logic        o_reg_we;
  logic [4:0]  o_regw_add;
  logic [31:0] o_reg_data;
  logic [31:0] o_busy;

  int errors;
  int checks;

  logic [31:0] rf [32];

  proc_wb_arbiter_if #(.NREQ(3), .AW(5), .BUS_WIDTH(32)) wb ();

  proc_wb_arbiter #(
    .BUS_WIDTH (32),
    .REG_DPTH  (32),
    .NREQ      (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb),
    .i_issue_vld (i_issue_vld),
    .i_issue_rd  (i_issue_rd),
    .i_rega_add  (i_rega_add),
    .i_regb_add  (i_regb_add),
    .o_hazard_a  (o_hazard_a),
    .o_hazard_b  (o_hazard_b),
    .o_reg_we    (o_reg_we),
    .o_regw_add  (o_regw_add),
    .o_reg_data  (o_reg_data),
    .o_busy      (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_reg_we) rf[o_regw_add] <= o_reg_data;

  typedef struct {
    logic [2:0]  vld;
    logic [4:0]  a0, a1, a2;
    logic        iv;
    logic [4:0]  ird, ra, rb;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  wadd;
    logic [31:0] wdata;
    logic        ha, hb;
  } vec_t;

  vec_t tbl [9];

  function automatic vec_t mk(
    input logic [2:0] vld, input logic [4:0] a0,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic [2:0] rdy, input logic we,
    input logic [4:0] wadd, input logic [31:0] wdata,
    input logic ha, input logic hb);
    vec_t v;
    v.vld = vld; v.a0 = a0; v.a1 = 5'd6; v.a2 = 5'd7;
    v.iv = iv; v.ird = ird; v.ra = ra; v.rb = rb;
    v.rdy = rdy; v.we = we; v.wadd = wadd; v.wdata = wdata;
    v.ha = ha; v.hb = hb;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a,
                         input logic [31:0] d);
    wb.add[i*5 +: 5]   = a;
    wb.data[i*32 +: 32] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    tbl[0] = mk(3'b111, 5'd5, 0, 5'd0, 5'd0, 5'd0, 3'b001, 1, 5'd5, 32'hA0, 0, 0);
    tbl[1] = mk(3'b111, 5'd5, 0, 5'd0, 5'd0, 5'd0, 3'b010, 1, 5'd6, 32'hA1, 0, 0);
    tbl[2] = mk(3'b111, 5'd5, 0, 5'd0, 5'd0, 5'd0, 3'b100, 1, 5'd7, 32'hA2, 0, 0);
    tbl[3] = mk(3'b111, 5'd5, 0, 5'd0, 5'd0, 5'd0, 3'b001, 1, 5'd5, 32'hA0, 0, 0);
    tbl[4] = mk(3'b000, 5'd5, 1, 5'd3, 5'd3, 5'd0, 3'b000, 0, 5'd0, 32'h0,  0, 0);
    tbl[5] = mk(3'b101, 5'd5, 0, 5'd0, 5'd3, 5'd0, 3'b100, 1, 5'd7, 32'hA2, 1, 0);
    tbl[6] = mk(3'b110, 5'd5, 0, 5'd0, 5'd0, 5'd3, 3'b010, 1, 5'd6, 32'hA1, 0, 1);
    tbl[7] = mk(3'b011, 5'd5, 0, 5'd0, 5'd3, 5'd3, 3'b001, 1, 5'd5, 32'hA0, 1, 1);
    tbl[8] = mk(3'b001, 5'd0, 0, 5'd0, 5'd5, 5'd0, 3'b001, 0, 5'd0, 32'h0,  0, 0);

    rst = 1'b1;
    wb.vld = 3'b111;
    set_req(0, 5'd5, 32'hA0);
    set_req(1, 5'd6, 32'hA1);
    set_req(2, 5'd7, 32'hA2);
    i_issue_vld = 1'b0;
    i_issue_rd  = '0;
    i_rega_add  = '0;
    i_regb_add  = '0;

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_rdy", 64'(wb.rdy), 64'd0);
      tick();
    end
    chk("rst_we", 64'(o_reg_we), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_add", 64'(o_regw_add), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      wb.vld      = tbl[i].vld;
      set_req(0, tbl[i].a0, 32'hA0);
      set_req(1, tbl[i].a1, 32'hA1);
      set_req(2, tbl[i].a2, 32'hA2);
      i_issue_vld = tbl[i].iv;
      i_issue_rd  = tbl[i].ird;
      i_rega_add  = tbl[i].ra;
      i_regb_add  = tbl[i].rb;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", i), 64'(wb.rdy), 64'(tbl[i].rdy));
      chk($sformatf("v%0d_haz_a", i), 64'(o_hazard_a), 64'(tbl[i].ha));
      chk($sformatf("v%0d_haz_b", i), 64'(o_hazard_b), 64'(tbl[i].hb));
      tick();
      chk($sformatf("v%0d_we", i), 64'(o_reg_we), 64'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("v%0d_add", i), 64'(o_regw_add), 64'(tbl[i].wadd));
        chk($sformatf("v%0d_data", i), 64'(o_reg_data), 64'(tbl[i].wdata));
      end
    end
    chk("x0_busy0", 64'(o_busy[0]), 64'd0);
    chk("busy3_held", 64'(o_busy[3]), 64'd1);
    wb.vld = 3'b000;
    i_issue_vld = 1'b0;
    i_rega_add = '0;
    i_regb_add = '0;
    tick();

    for (int k = 0; k < 4; k++) begin
      wb.vld = 3'b010;
      set_req(1, 5'd12, 32'h11 + 32'(k));
      @(negedge clk);
      chk($sformatf("b2b%0d_rdy", k), 64'(wb.rdy), 64'b010);
      tick();
      chk($sformatf("b2b%0d_we", k), 64'(o_reg_we), 64'd1);
      chk($sformatf("b2b%0d_add", k), 64'(o_regw_add), 64'd12);
      chk($sformatf("b2b%0d_data", k), 64'(o_reg_data), 64'(32'h11 + 32'(k)));
    end
    wb.vld = 3'b000;
    tick();
    chk("b2b_rf12", 64'(rf[12]), 64'h14);

    i_issue_vld = 1'b1;
    i_issue_rd  = 5'd9;
    tick();
    i_issue_vld = 1'b0;
    chk("sb_c1_busy9", 64'(o_busy[9]), 64'd1);
    tick();
    chk("sb_c2_busy9", 64'(o_busy[9]), 64'd1);
    tick();
    wb.vld = 3'b100;
    set_req(2, 5'd9, 32'hDEADBEEF);
    i_rega_add = 5'd9;
    @(negedge clk);
    chk("sb_c3_rdy", 64'(wb.rdy), 64'b100);
    chk("sb_c3_haz_a", 64'(o_hazard_a), 64'd1);
    tick();
    wb.vld = 3'b000;
    chk("sb_c4_we", 64'(o_reg_we), 64'd1);
    chk("sb_c4_add", 64'(o_regw_add), 64'd9);
    chk("sb_c4_busy9", 64'(o_busy[9]), 64'd1);
    tick();
    chk("sb_c5_busy9", 64'(o_busy[9]), 64'd0);
    chk("sb_c5_haz_a", 64'(o_hazard_a), 64'd0);
    chk("sb_c5_rf9", 64'(rf[9]), 64'hDEADBEEF);
    i_rega_add = '0;

    i_issue_vld = 1'b1;
    i_issue_rd  = 5'd4;
    tick();
    i_issue_vld = 1'b0;
    chk("col_busy4_set", 64'(o_busy[4]), 64'd1);
    wb.vld = 3'b001;
    set_req(0, 5'd4, 32'h44);
    @(negedge clk);
    chk("col_rdy", 64'(wb.rdy), 64'b001);
    tick();
    wb.vld = 3'b000;
    chk("col_we", 64'(o_reg_we), 64'd1);
    i_issue_vld = 1'b1;
    i_issue_rd  = 5'd4;
    tick();
    i_issue_vld = 1'b0;
    chk("col_busy4_kept", 64'(o_busy[4]), 64'd1);
    chk("col_rf4", 64'(rf[4]), 64'h44);
    chk("col_busy0", 64'(o_busy[0]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
